// File: rtl/tetris_pkg.sv
// Shared types and defaults for the tetris playfield memory slice.
// FSM encoding, grid/window defaults, width helper.
package tetris_pkg;

  localparam int GRID_W_DEF        = 8;
  localparam int GRID_H_DEF        = 18;
  localparam int WINDOW_CYCLES_DEF = 1600;
  localparam int COORD_W           = 8;

  typedef enum logic [1:0] {
    ST_DISPLAY = 2'd0,
    ST_WINDOW  = 2'd1,
    ST_CLEAR   = 2'd2
  } arb_state_t;

  function automatic int cbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/field_store.sv
// One-bit-per-cell playfield storage.
// Comb + registered read, single write, row clear.
module field_store
  import tetris_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [COORD_W-1:0]        cx,
  input  logic [COORD_W-1:0]        cy,
  output logic                      cval,
  input  logic                      rd_en,
  input  logic [COORD_W-1:0]        rx,
  input  logic [COORD_W-1:0]        ry,
  output logic                      rd_data,
  input  logic                      we,
  input  logic [COORD_W-1:0]        wx,
  input  logic [COORD_W-1:0]        wy,
  input  logic                      wd,
  input  logic                      clr_en,
  input  logic [cbits(GRID_H)-1:0]  clr_row
);

  localparam int XW = cbits(GRID_W);
  localparam int YW = cbits(GRID_H);
  localparam logic [COORD_W-1:0] W_LIM = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(GRID_H);

  logic [GRID_W-1:0] cells [GRID_H];
  logic c_hit, r_hit, w_hit;

  assign c_hit = (cx < W_LIM) && (cy < H_LIM);
  assign r_hit = (rx < W_LIM) && (ry < H_LIM);
  assign w_hit = (wx < W_LIM) && (wy < H_LIM);

  assign cval = c_hit ? cells[cy[YW-1:0]][cx[XW-1:0]] : 1'b0;

  // Cell updates, row clears and the registered game read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < GRID_H; r++) cells[r] <= '0;
      rd_data <= 1'b0;
    end else begin
      if (we && w_hit)
        cells[wy[YW-1:0]][wx[XW-1:0]] <= wd;
      if (clr_en)
        cells[clr_row] <= '0;
      if (rd_en)
        rd_data <= r_hit ? cells[ry[YW-1:0]][rx[XW-1:0]] : 1'b0;
    end
  end

endmodule

// File: rtl/field_mem_arbiter.sv
// Shares the playfield between VGA scan-out and the game.
// Game ops are served only in a per-frame access window.
module field_mem_arbiter
  import tetris_pkg::*;
#(
  parameter int GRID_W        = GRID_W_DEF,
  parameter int GRID_H        = GRID_H_DEF,
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               draw_finish,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  output logic               coord_value,
  input  logic               wr_req,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_data,
  output logic               wr_ack,
  input  logic               rd_req,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               rd_ack,
  output logic               rd_data,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               window_open,
  output logic [7:0]         frame_cnt
);

  localparam int CNT_W = cbits(WINDOW_CYCLES);
  localparam int ROW_W = cbits(GRID_H);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_H - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] win_cnt;
  logic [ROW_W-1:0] row;
  logic             pending;
  logic             in_win;
  logic             serve_wr;
  logic             serve_rd;
  logic             start_clr;

  assign in_win    = (state == ST_WINDOW);
  assign serve_wr  = in_win & wr_req;
  assign serve_rd  = in_win & rd_req & ~wr_req;
  assign wr_ack    = serve_wr;
  assign rd_ack    = serve_rd;
  assign start_clr = (state == ST_DISPLAY) & draw_finish & pending;
  assign clr_busy  = pending | (state == ST_CLEAR);

  // Frame sequencing: display, optional clear sweep, access window.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_DISPLAY;
      win_cnt     <= '0;
      row         <= '0;
      window_open <= 1'b0;
    end else begin
      unique case (state)
        ST_DISPLAY: begin
          if (draw_finish) begin
            if (pending) begin
              state <= ST_CLEAR;
              row   <= '0;
            end else begin
              state       <= ST_WINDOW;
              win_cnt     <= CNT_LOAD;
              window_open <= 1'b1;
            end
          end
        end
        ST_WINDOW: begin
          if (win_cnt == '0) begin
            state       <= ST_DISPLAY;
            window_open <= 1'b0;
          end else begin
            win_cnt <= win_cnt - 1'b1;
          end
        end
        ST_CLEAR: begin
          if (row == ROW_LAST) begin
            state       <= ST_WINDOW;
            win_cnt     <= CNT_LOAD;
            window_open <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end
        default: begin
          state       <= ST_DISPLAY;
          window_open <= 1'b0;
        end
      endcase
    end
  end

  // Clear request latch and free-running frame counter.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (clr_req)
        pending <= 1'b1;
      else if (start_clr)
        pending <= 1'b0;
      if (draw_finish)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  field_store #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_store (
    .clk     (vga_clk),
    .rst_n   (rst_n),
    .cx      (x_coord),
    .cy      (y_coord),
    .cval    (coord_value),
    .rd_en   (serve_rd),
    .rx      (rd_x),
    .ry      (rd_y),
    .rd_data (rd_data),
    .we      (serve_wr),
    .wx      (wr_x),
    .wy      (wr_y),
    .wd      (wr_data),
    .clr_en  (state == ST_CLEAR),
    .clr_row (row)
  );

endmodule

// File: tb/tb_field_mem_arbiter.sv
// Scoreboard bench for field_mem_arbiter.
// Directed ops; monitor pops expectations on each ack.
module tb_field_mem_arbiter;

  logic       vga_clk;
  logic       rst_n;
  logic       draw_finish;
  logic       df_man, df_auto, auto_df;
  logic [7:0] x_coord, y_coord;
  logic       coord_value;
  logic       wr_req, wr_data, wr_ack;
  logic [7:0] wr_x, wr_y;
  logic       rd_req, rd_ack, rd_data;
  logic [7:0] rd_x, rd_y;
  logic       clr_req, clr_busy, window_open;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic is_wr;
    logic data;
  } exp_t;

  exp_t sb[$];

  assign draw_finish = df_man | df_auto;

  field_mem_arbiter #(
    .GRID_W        (8),
    .GRID_H        (18),
    .WINDOW_CYCLES (4)
  ) dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .draw_finish (draw_finish),
    .x_coord     (x_coord),
    .y_coord     (y_coord),
    .coord_value (coord_value),
    .wr_req      (wr_req),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd_req      (rd_req),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .window_open (window_open),
    .frame_cnt   (frame_cnt)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // background frame generator: one draw_finish every 12 cycles
  initial begin
    int dfc;
    dfc = 0;
    df_auto = 1'b0;
    forever begin
      @(posedge vga_clk);
      #1;
      if (auto_df) begin
        if (dfc == 11) begin
          df_auto = 1'b1;
          dfc = 0;
        end else begin
          df_auto = 1'b0;
          dfc++;
        end
      end else begin
        df_auto = 1'b0;
      end
    end
  end

  // monitor: pops one expectation per ack, checks rd_data a cycle later
  initial begin
    logic rd_pend;
    logic rd_exp;
    exp_t e;
    rd_pend = 1'b0;
    rd_exp  = 1'b0;
    forever begin
      @(negedge vga_clk);
      if (!rst_n) begin
        rd_pend = 1'b0;
      end else begin
        if (rd_pend) begin
          chk("rd_data", rd_data, rd_exp);
          rd_pend = 1'b0;
        end
        if (wr_ack || rd_ack) begin
          chk("ack_in_window", window_open, 1);
          chk("ack_onehot", wr_ack & rd_ack, 0);
          if (sb.size() == 0) begin
            chk("unexpected_ack", {wr_ack, rd_ack}, 0);
          end else begin
            e = sb.pop_front();
            chk("ack_kind", wr_ack, e.is_wr);
            if (!e.is_wr) begin
              rd_pend = 1'b1;
              rd_exp  = e.data;
            end
          end
        end
      end
    end
  end

  task automatic pulse_df();
    @(posedge vga_clk);
    #1 df_man = 1'b1;
    @(posedge vga_clk);
    #1 df_man = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] x, input logic [7:0] y,
                          input logic d);
    bit got;
    sb.push_back('{1'b1, 1'b0});
    @(posedge vga_clk);
    #1;
    wr_x = x; wr_y = y; wr_data = d; wr_req = 1'b1;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge vga_clk);
      if (wr_ack) got = 1;
    end
    chk("wr_timeout", got, 1);
    @(posedge vga_clk);
    #1 wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] x, input logic [7:0] y,
                         input logic exp);
    bit got;
    sb.push_back('{1'b0, exp});
    @(posedge vga_clk);
    #1;
    rd_x = x; rd_y = y; rd_req = 1'b1;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge vga_clk);
      if (rd_ack) got = 1;
    end
    chk("rd_timeout", got, 1);
    @(posedge vga_clk);
    #1 rd_req = 1'b0;
  endtask

  task automatic wait_display();
    bit idle;
    idle = 0;
    for (int n = 0; n < 100 && !idle; n++) begin
      @(negedge vga_clk);
      if (!window_open && !clr_busy) idle = 1;
    end
    chk("idle_timeout", idle, 1);
  endtask

  task automatic peek(input string nm, input logic [7:0] x,
                      input logic [7:0] y, input logic exp);
    x_coord = x;
    y_coord = y;
    #1 chk(nm, coord_value, exp);
  endtask

  task automatic check_all(input string nm, input logic v);
    int errs;
    errs = 0;
    for (int y = 0; y < 18; y++)
      for (int x = 0; x < 8; x++) begin
        x_coord = 8'(x);
        y_coord = 8'(y);
        #1 if (coord_value !== v) errs++;
      end
    chk(nm, errs, 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; df_man = 1'b0; auto_df = 1'b0;
    x_coord = '0; y_coord = '0;
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = 1'b0;
    rd_req = 1'b0; rd_x = '0; rd_y = '0; clr_req = 1'b0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst_window_open", window_open, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_cell", coord_value, 0);
    rst_n = 1'b1;

    // write held from DISPLAY, acked in first window cycle
    @(posedge vga_clk);
    #1;
    wr_x = 8'd3; wr_y = 8'd5; wr_data = 1'b1; wr_req = 1'b1;
    sb.push_back('{1'b1, 1'b0});
    cnt = 0;
    repeat (3) begin
      @(negedge vga_clk);
      if (wr_ack) cnt++;
    end
    chk("stall_display", cnt, 0);
    pulse_df();
    @(negedge vga_clk);
    chk("first_win_open", window_open, 1);
    chk("first_win_ack", wr_ack, 1);
    @(posedge vga_clk);
    #1 wr_req = 1'b0;
    wait_display();
    peek("cell_3_5", 8'd3, 8'd5, 1);
    peek("cell_3_6", 8'd3, 8'd6, 0);
    chk("frame_cnt_1", frame_cnt, 1);

    // simultaneous write and read to the same cell
    @(posedge vga_clk);
    #1;
    wr_x = 8'd2; wr_y = 8'd7; wr_data = 1'b1; wr_req = 1'b1;
    rd_x = 8'd2; rd_y = 8'd7; rd_req = 1'b1;
    sb.push_back('{1'b1, 1'b0});
    sb.push_back('{1'b0, 1'b1});
    pulse_df();
    @(negedge vga_clk);
    chk("prio_wr_ack", wr_ack, 1);
    chk("prio_rd_wait", rd_ack, 0);
    @(posedge vga_clk);
    #1 wr_req = 1'b0;
    @(negedge vga_clk);
    chk("prio_rd_ack", rd_ack, 1);
    @(posedge vga_clk);
    #1 rd_req = 1'b0;
    wait_display();

    // window length and late request
    pulse_df();
    cnt = 0;
    repeat (4) begin
      @(negedge vga_clk);
      if (window_open) cnt++;
    end
    @(posedge vga_clk);
    #1;
    wr_x = 8'd4; wr_y = 8'd4; wr_data = 1'b1; wr_req = 1'b1;
    sb.push_back('{1'b1, 1'b0});
    @(negedge vga_clk);
    chk("win_len", cnt, 4);
    chk("win_closed", window_open, 0);
    chk("late_no_ack", wr_ack, 0);
    cnt = 0;
    repeat (4) begin
      @(negedge vga_clk);
      if (wr_ack) cnt++;
    end
    chk("late_stall", cnt, 0);
    pulse_df();
    @(negedge vga_clk);
    chk("late_next_frame_ack", wr_ack, 1);
    @(posedge vga_clk);
    #1 wr_req = 1'b0;
    wait_display();

    // out-of-range accesses
    auto_df = 1'b1;
    do_write(8'd1, 8'd0, 1'b1);
    do_write(8'd0, 8'd18, 1'b1);
    do_read(8'd9, 8'd0, 1'b0);
    do_read(8'd1, 8'd0, 1'b1);
    auto_df = 1'b0;
    wait_display();
    peek("oor_view_9_0", 8'd9, 8'd0, 0);
    peek("oor_view_0_18", 8'd0, 8'd18, 0);
    peek("oor_alias_0_2", 8'd0, 8'd2, 0);
    peek("inr_1_0", 8'd1, 8'd0, 1);

    // fill, then whole-field clear
    auto_df = 1'b1;
    for (int y = 0; y < 18; y++)
      for (int x = 0; x < 8; x++)
        do_write(8'(x), 8'(y), 1'b1);
    auto_df = 1'b0;
    wait_display();
    check_all("fill_all_ones", 1'b1);
    @(posedge vga_clk);
    #1 clr_req = 1'b1;
    @(posedge vga_clk);
    #1 clr_req = 1'b0;
    @(negedge vga_clk);
    chk("clr_pending_busy", clr_busy, 1);
    chk("clr_no_window", window_open, 0);
    pulse_df();
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge vga_clk);
      if (window_open) break;
      if (clr_busy) cnt++;
    end
    chk("clr_cycles", cnt, 18);
    chk("clr_done_busy", clr_busy, 0);
    check_all("clr_all_zero", 1'b0);
    wait_display();

    // reset in the middle of a clear sweep
    auto_df = 1'b1;
    do_write(8'd5, 8'd17, 1'b1);
    do_read(8'd5, 8'd17, 1'b1);
    auto_df = 1'b0;
    wait_display();
    @(posedge vga_clk);
    #1 clr_req = 1'b1;
    @(posedge vga_clk);
    #1;
    clr_req = 1'b0;
    wr_x = 8'd6; wr_y = 8'd6; wr_data = 1'b1; wr_req = 1'b1;
    pulse_df();
    x_coord = 8'd5;
    y_coord = 8'd17;
    repeat (7) @(posedge vga_clk);
    #1;
    chk("midclr_busy", clr_busy, 1);
    chk("midclr_row17", coord_value, 1);
    chk("midclr_rd_data", rd_data, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_window_open", window_open, 0);
    chk("arst_wr_ack", wr_ack, 0);
    chk("arst_rd_ack", rd_ack, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_clr_busy", clr_busy, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_cell", coord_value, 0);
    repeat (2) @(negedge vga_clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge vga_clk);
      if (wr_ack || window_open || clr_busy) cnt++;
    end
    chk("post_rst_idle", cnt, 0);
    @(posedge vga_clk);
    #1 wr_req = 1'b0;

    // frame counter wrap
    repeat (255) pulse_df();
    @(negedge vga_clk);
    chk("frame_cnt_255", frame_cnt, 255);
    pulse_df();
    @(negedge vga_clk);
    chk("frame_cnt_wrap", frame_cnt, 0);
    wait_display();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
